fetch_mem_arbiter: RTL
======================

Name: fetch_mem_arbiter

Overview:
- Shares a single RAM port between the fetch stage (instruction requester) and the memory stage (data requester). Supplies ihit/iload to fetch and dhit/dload to data.
- Data wins by default. A starvation counter guarantees instruction progress.
- A misprediction abort squashes an in-flight instruction fetch, so fetch never receives a stale instruction.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data word width.
- STARVE_LIMIT, 4, maximum consecutive data grants while iren is pending before instruction is forced.

Ports:
- CLK  in  1  clock, rising edge.
- nRST  in  1  asynchronous active-low reset.
- iren  in  1  instruction read request; held until ihit.
- iaddr  in  ADDR_W  instruction address.
- iabort  in  1  misprediction/flush from fetch; squashes outstanding instruction fetch.
- ihit  out  1  one-cycle instruction completion pulse.
- iload  out  DATA_W  fetched instruction, valid with ihit.
- dren  in  1  data read request; held until dhit.
- dwen  in  1  data write request; held until dhit.
- daddr  in  ADDR_W  data address.
- dstore  in  DATA_W  write data.
- dhit  out  1  one-cycle data completion pulse.
- dload  out  DATA_W  read data, valid with dhit on reads.
- ram_addr  out  ADDR_W  RAM address.
- ram_store  out  DATA_W  RAM write data.
- ram_ren  out  1  RAM read enable.
- ram_wen  out  1  RAM write enable.
- ram_ready  in  1  RAM access complete; ram_load valid this cycle.
- ram_load  in  DATA_W  RAM read data.

Behaviour:
- Reset: all outputs 0, state IDLE, starve_cnt 0, squash 0. Reset mid-transaction drops the transaction and produces no hit.
- All outputs are registered.
- States: IDLE, IREQ, DREQ, RESP.
- IDLE, data request present (dren|dwen):
  - If iren and starve_cnt==STARVE_LIMIT: go to IREQ, clear starve_cnt.
  - Otherwise go to DREQ. starve_cnt increments if iren=1, and clears if iren=0.
- IDLE, iren only: go to IREQ, clear starve_cnt.
- IDLE, nothing pending: stay in IDLE.
- On grant, latch address/store/write into ram_addr/ram_store/ram_ren/ram_wen.
- dwen and dren both high: perform a write (ram_wen=1, ram_ren=0).
- IREQ/DREQ: RAM outputs are held stable until ram_ready is sampled high. At that edge:
  - Capture ram_load into iload/dload. dload is unchanged on writes.
  - Deassert ram_ren/ram_wen.
  - Go to RESP.
- RESP: exactly one cycle.
  - ihit=1 (IREQ source, squash=0) or dhit=1 (DREQ source).
  - No grant is made in RESP, so a requester still asserted in the hit cycle is not re-served.
  - Then go to IDLE.
- Squash: iabort=1 in any IREQ cycle, including the ram_ready cycle, sets squash. The RAM access still completes (it is not cancellable). ihit is suppressed in RESP and iload is not updated. squash clears on entry to IDLE.
- iabort in IDLE, DREQ or RESP has no effect.
- Minimum latency: request sampled at edge 0, RAM enable visible cycle 1, ram_ready in cycle 1, hit in cycle 2, next grant at the edge ending cycle 3.
- Requester inputs changing while not granted are ignored. The latched copy is used during the access.
- ram_ready in IDLE/RESP is ignored.

Test Plan:
- Reset:
  - Assert nRST=0 mid-DREQ → all outputs 0 immediately.
  - After release with no requests, state IDLE, no hits.
- Instruction fetch:
  - iren=1, iaddr=0x10, ram_ready 2 cycles after ram_ren, ram_load=0x00000080.
  - Required: ram_addr=0x10, ram_ren=1, ram_wen=0; one ihit pulse with iload=0x00000080; exactly one RAM access.
- Data priority:
  - dren and iren both asserted with daddr=0x200 and iaddr=0x14.
  - Required: first access ram_addr=0x200 with dhit; then iaddr=0x14 is served with ihit.
  - A write with dwen=1, dstore=0xDEADBEEF drives ram_wen=1 and ram_store=0xDEADBEEF.
- Starvation:
  - Hold dren and iren continuously, STARVE_LIMIT=4.
  - Required: 4 dhits, then 1 ihit, repeating.
- Abort:
  - Pulse iabort during IREQ for iaddr=0x80000000.
  - Required: RAM access completes, no ihit, iload unchanged.
  - Next iren to 0x80000100 returns a normal ihit.
- Back-to-back:
  - iren held through ihit.
  - Required: no second access issued from the RESP cycle; the next grant occurs only from IDLE.

Source files
------------

// File: rtl/fetch_mem_arbiter.sv
// Arbitrates one RAM port between instruction fetch and data memory access.
// Data wins by default; a starvation counter forces an instruction grant.
module fetch_mem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              iren,
  input  logic [ADDR_W-1:0] iaddr,
  input  logic              iabort,
  output logic              ihit,
  output logic [DATA_W-1:0] iload,
  input  logic              dren,
  input  logic              dwen,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic              dhit,
  output logic [DATA_W-1:0] dload,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_store,
  output logic              ram_ren,
  output logic              ram_wen,
  input  logic              ram_ready,
  input  logic [DATA_W-1:0] ram_load,
  output logic [1:0]        dbg_state
);

  // Handshake: each requester holds its request until its one-cycle hit pulse;
  // the RAM holds ram_ready high for the single cycle that completes an access.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IREQ = 2'd1,
    DREQ = 2'd2,
    RESP = 2'd3
  } state_t;

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  starve_q, starve_d;
  logic              squash_q, squash_d;
  logic              ihit_d, dhit_d;
  logic [DATA_W-1:0] iload_d, dload_d;
  logic [ADDR_W-1:0] ram_addr_d;
  logic [DATA_W-1:0] ram_store_d;
  logic              ram_ren_d, ram_wen_d;

  assign dbg_state = state_q;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q   <= IDLE;
      starve_q  <= '0;
      squash_q  <= 1'b0;
      ihit      <= 1'b0;
      dhit      <= 1'b0;
      iload     <= '0;
      dload     <= '0;
      ram_addr  <= '0;
      ram_store <= '0;
      ram_ren   <= 1'b0;
      ram_wen   <= 1'b0;
    end else begin
      state_q   <= state_d;
      starve_q  <= starve_d;
      squash_q  <= squash_d;
      ihit      <= ihit_d;
      dhit      <= dhit_d;
      iload     <= iload_d;
      dload     <= dload_d;
      ram_addr  <= ram_addr_d;
      ram_store <= ram_store_d;
      ram_ren   <= ram_ren_d;
      ram_wen   <= ram_wen_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    squash_d    = squash_q;
    ihit_d      = 1'b0;
    dhit_d      = 1'b0;
    iload_d     = iload;
    dload_d     = dload;
    ram_addr_d  = ram_addr;
    ram_store_d = ram_store;
    ram_ren_d   = ram_ren;
    ram_wen_d   = ram_wen;
    unique case (state_q)
      IDLE: begin
        squash_d = 1'b0;
        if ((dren || dwen) && !(iren && starve_q == LIMIT)) begin
          state_d     = DREQ;
          starve_d    = iren ? starve_q + 1'b1 : '0;
          ram_addr_d  = daddr;
          ram_store_d = dstore;
          // A simultaneous read and write request is served as a write.
          ram_wen_d   = dwen;
          ram_ren_d   = ~dwen;
        end else if (iren) begin
          state_d    = IREQ;
          starve_d   = '0;
          ram_addr_d = iaddr;
          ram_ren_d  = 1'b1;
          ram_wen_d  = 1'b0;
        end
      end
      IREQ: begin
        if (iabort) squash_d = 1'b1;
        if (ram_ready) begin
          state_d   = RESP;
          ram_ren_d = 1'b0;
          ram_wen_d = 1'b0;
          // An abort in the completing cycle counts as well as an earlier one.
          if (!(squash_q || iabort)) begin
            ihit_d  = 1'b1;
            iload_d = ram_load;
          end
        end
      end
      DREQ: begin
        if (ram_ready) begin
          state_d   = RESP;
          ram_ren_d = 1'b0;
          ram_wen_d = 1'b0;
          dhit_d    = 1'b1;
          if (!ram_wen) dload_d = ram_load;
        end
      end
      RESP: begin
        state_d  = IDLE;
        squash_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
